// File: rtl/ball_motion.sv
// Ball position/direction tracker: steps the ball each frame tick, bouncing off walls, the paddle
// and brick hits. Define SPEEDUP_EN to build the paddle-hit counter that raises the speed.
module ball_motion #(
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned STEP_W       = 4,
    parameter int unsigned X_START      = 316,
    parameter int unsigned Y_START      = 400,
    parameter int unsigned SPEEDUP_HITS = 4,
    parameter int unsigned STEP_MAX     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               launch,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_max,
    input  logic [COORD_W-1:0] size,
    input  logic [STEP_W-1:0]  step,
    input  logic [COORD_W-1:0] paddle_x,
    input  logic [COORD_W-1:0] paddle_w,
    input  logic               brick_hit_x,
    input  logic               brick_hit_y,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               x_du,
    output logic               y_du,
    output logic               lost,
    output logic [1:0]         state,
    output logic [STEP_W-1:0]  speed
);

    localparam int unsigned CW1 = COORD_W + 1;
    localparam logic [COORD_W-1:0] XStart = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] YStart = COORD_W'(Y_START);

    typedef enum logic [1:0] {StIdle = 2'd0, StMove = 2'd1, StLost = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic                 x_du_q, x_du_d, y_du_q, y_du_d;
    logic                 lost_q, lost_d;
    logic [STEP_W-1:0]    speed_q, speed_d, launch_speed;
    logic                 bx_q, bx_d, by_q, by_d;

    logic [CW1-1:0]       xl, yl, spd, nx, ny;
    logic [COORD_W-1:0]   xm, ym;
    logic                 move_en, flip_x, flip_y, overlap, bottom_hit, miss;

`ifdef SPEEDUP_EN
    localparam int unsigned HitW = $clog2(SPEEDUP_HITS + 1);
    logic [HitW-1:0] hits_q, hits_d;
    assign launch_speed = (step > STEP_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : step;
`else
    assign launch_speed = step;
`endif

    // Saturating limits so a ball larger than the field pins to 0 instead of wrapping.
    assign xl       = (size >= x_max) ? '0 : (CW1'(x_max) - CW1'(size));
    assign yl       = (size >= y_max) ? '0 : (CW1'(y_max) - CW1'(size));
    assign spd      = CW1'(speed_q);
    assign nx       = CW1'(x_q) + spd;
    assign ny       = CW1'(y_q) + spd;
    assign xm       = x_q - COORD_W'(speed_q);
    assign ym       = y_q - COORD_W'(speed_q);
    assign move_en  = (state_q == StMove) && tick && (speed_q != '0);
    assign flip_x   = bx_q | brick_hit_x;
    assign flip_y   = by_q | brick_hit_y;
    assign overlap  = ((CW1'(x_q) + CW1'(size)) > CW1'(paddle_x)) &&
                      (CW1'(x_q) < (CW1'(paddle_x) + CW1'(paddle_w)));
    assign bottom_hit = move_en && y_du_q && (ny >= yl);
    assign miss       = bottom_hit && !overlap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (launch) state_d = StMove;
            StMove:  if (miss) state_d = StLost;
            StLost:  if (launch) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        x_du_d  = x_du_q;
        y_du_d  = y_du_q;
        speed_d = speed_q;
        bx_d    = bx_q;
        by_d    = by_q;
        lost_d  = 1'b0;
`ifdef SPEEDUP_EN
        hits_d  = hits_q;
`endif
        unique case (state_q)
            StIdle: begin
                x_d  = XStart;
                y_d  = YStart;
                bx_d = 1'b0;
                by_d = 1'b0;
                if (launch) begin
                    speed_d = launch_speed;
                    x_du_d  = 1'b1;
                    y_du_d  = 1'b0;
                end
            end
            StMove: begin
                // Latches collect brick pulses between ticks and are consumed by the next tick.
                bx_d   = tick ? 1'b0 : flip_x;
                by_d   = tick ? 1'b0 : flip_y;
                lost_d = miss;
                if (move_en && x_du_q && (nx >= xl)) begin
                    x_d    = xl[COORD_W-1:0];
                    x_du_d = 1'b0;
                end else if (move_en && !x_du_q && (CW1'(x_q) <= spd)) begin
                    x_d    = '0;
                    x_du_d = 1'b1;
                end else begin
                    if (move_en) x_d = x_du_q ? nx[COORD_W-1:0] : xm;
                    if (tick) x_du_d = x_du_q ^ flip_x;
                end
                if (move_en && !y_du_q && (CW1'(y_q) <= spd)) begin
                    y_d    = '0;
                    y_du_d = 1'b1;
                end else if (bottom_hit) begin
                    y_d = yl[COORD_W-1:0];
                    if (overlap) y_du_d = 1'b0;
                end else begin
                    if (move_en) y_d = y_du_q ? ny[COORD_W-1:0] : ym;
                    if (tick) y_du_d = y_du_q ^ flip_y;
                end
`ifdef SPEEDUP_EN
                if (bottom_hit && overlap) begin
                    if (hits_q == HitW'(SPEEDUP_HITS - 1)) begin
                        hits_d = '0;
                        if (speed_q < STEP_W'(STEP_MAX)) speed_d = speed_q + 1'b1;
                    end else begin
                        hits_d = hits_q + 1'b1;
                    end
                end
`endif
            end
            StLost: begin
                bx_d = 1'b0;
                by_d = 1'b0;
                if (launch) begin
                    x_d    = XStart;
                    y_d    = YStart;
                    x_du_d = 1'b1;
                    y_du_d = 1'b0;
`ifdef SPEEDUP_EN
                    hits_d = '0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= XStart;
            y_q     <= YStart;
            x_du_q  <= 1'b1;
            y_du_q  <= 1'b0;
            lost_q  <= 1'b0;
            speed_q <= '0;
            bx_q    <= 1'b0;
            by_q    <= 1'b0;
`ifdef SPEEDUP_EN
            hits_q  <= '0;
`endif
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            x_du_q  <= x_du_d;
            y_du_q  <= y_du_d;
            lost_q  <= lost_d;
            speed_q <= speed_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
`ifdef SPEEDUP_EN
            hits_q  <= hits_d;
`endif
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign x_du  = x_du_q;
    assign y_du  = y_du_q;
    assign lost  = lost_q;
    assign state = state_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: directed stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them when they fall due.
module tb_ball_motion;

    logic       clk, reset, tick, launch, brick_hit_x, brick_hit_y;
    logic [9:0] x_max, y_max, size, paddle_x, paddle_w;
    logic [3:0] step;
    logic [9:0] x, y;
    logic       x_du, y_du, lost;
    logic [1:0] state;
    logic [3:0] speed;

    typedef struct {
        int         due;
        string      nm;
        logic [9:0] x, y;
        logic       xd, yd, ls;
        logic [1:0] st;
        logic [3:0] sp;
        bit         sp_only;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    ball_motion #(
        .COORD_W(10), .STEP_W(4), .X_START(316), .Y_START(400),
        .SPEEDUP_HITS(4), .STEP_MAX(5)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .launch(launch),
        .x_max(x_max), .y_max(y_max), .size(size), .step(step),
        .paddle_x(paddle_x), .paddle_w(paddle_w),
        .brick_hit_x(brick_hit_x), .brick_hit_y(brick_hit_y),
        .x(x), .y(y), .x_du(x_du), .y_du(y_du), .lost(lost),
        .state(state), .speed(speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ok;
        while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            compared++;
            if (e.sp_only) ok = (state === e.st) && (speed === e.sp);
            else ok = ({x, y, x_du, y_du, state, lost, speed} ===
                       {e.x, e.y, e.xd, e.yd, e.st, e.ls, e.sp});
            if (!ok) begin
                mismatched++;
                $display("FAIL %s: got x=%0d y=%0d xdu=%0b ydu=%0b st=%0d lost=%0b sp=%0d, want x=%0d y=%0d xdu=%0b ydu=%0b st=%0d lost=%0b sp=%0d%s",
                         e.nm, x, y, x_du, y_du, state, lost, speed,
                         e.x, e.y, e.xd, e.yd, e.st, e.ls, e.sp,
                         e.sp_only ? " (state/speed only)" : "");
            end
        end
    end

    task automatic drv(input logic rs, input logic t, input logic bxi, input logic byi,
                       input logic ln);
        @(negedge clk);
        reset       = rs;
        tick        = t;
        brick_hit_x = bxi;
        brick_hit_y = byi;
        launch      = ln;
    endtask

    task automatic expect_all(input string nm, input int ex, input int ey, input logic exd,
                              input logic eyd, input int est, input logic els, input int esp);
        exp_t e;
        e.due = cyc + 1; e.nm = nm; e.x = 10'(ex); e.y = 10'(ey);
        e.xd = exd; e.yd = eyd; e.st = 2'(est); e.ls = els; e.sp = 4'(esp); e.sp_only = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic expect_speed(input string nm, input int est, input int esp);
        exp_t e;
        e.due = cyc + 1; e.nm = nm; e.x = '0; e.y = '0; e.xd = 1'b0; e.yd = 1'b0;
        e.st = 2'(est); e.ls = 1'b0; e.sp = 4'(esp); e.sp_only = 1'b1;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; launch = 1'b0; brick_hit_x = 1'b0; brick_hit_y = 1'b0;
        x_max = 10'd640; y_max = 10'd480; size = 10'd8; step = 4'd2;
        paddle_x = 10'd0; paddle_w = 10'd1023;

        drv(1, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0); expect_all("reset", 316, 400, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1); expect_all("launch", 316, 400, 1, 0, 1, 0, 2);
        drv(0, 1, 0, 0, 0); expect_all("tick1", 318, 398, 1, 0, 1, 0, 2);

        // Pull the right wall in to xl=321.
        drv(0, 1, 0, 0, 0); x_max = 10'd329; expect_all("xwall_near", 320, 396, 1, 0, 1, 0, 2);
        drv(0, 1, 0, 0, 0); expect_all("xwall_bounce", 321, 394, 0, 0, 1, 0, 2);
        drv(0, 1, 0, 0, 0); expect_all("xwall_after", 319, 392, 0, 0, 1, 0, 2);
        drv(0, 0, 0, 0, 0); x_max = 10'd1023;

        // Brick x pulse three cycles ahead of the tick.
        drv(0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0); expect_all("brick_x_latched", 317, 390, 1, 0, 1, 0, 2);
        drv(0, 1, 0, 0, 0); expect_all("brick_x_cleared", 319, 388, 1, 0, 1, 0, 2);

        for (int k = 1; k <= 193; k++) begin
            drv(0, 1, 0, 0, 0); expect_all("climb", 319 + 2 * k, 388 - 2 * k, 1, 0, 1, 0, 2);
        end
        drv(0, 1, 0, 1, 0); expect_all("top_wall_brick", 707, 0, 1, 1, 1, 0, 2);
        drv(0, 1, 0, 0, 0); expect_all("top_after", 709, 2, 1, 1, 1, 0, 2);
        drv(0, 1, 1, 0, 0); expect_all("brick_x_same_tick", 711, 4, 0, 1, 1, 0, 2);
        drv(0, 1, 0, 0, 0); expect_all("brick_x_same_after", 709, 6, 0, 1, 1, 0, 2);

        // Paddle line at yl=10, paddle spanning 700..739.
        drv(0, 1, 0, 0, 0); y_max = 10'd18; paddle_x = 10'd700; paddle_w = 10'd40;
        expect_all("paddle_approach", 707, 8, 0, 1, 1, 0, 2);
        drv(0, 1, 0, 0, 0); expect_all("paddle_bounce", 705, 10, 0, 0, 1, 0, 2);
        drv(0, 0, 0, 1, 0);
        drv(0, 1, 0, 0, 0); expect_all("brick_y_down", 703, 8, 0, 1, 1, 0, 2);
        drv(0, 1, 0, 0, 0); paddle_x = 10'd100;
        expect_all("miss", 701, 10, 0, 1, 2, 1, 2);
        drv(0, 0, 0, 0, 0); expect_all("lost_pulse_end", 701, 10, 0, 1, 2, 0, 2);
        drv(0, 0, 1, 1, 0);
        drv(0, 1, 0, 0, 0); expect_all("lost_frozen", 701, 10, 0, 1, 2, 0, 2);

        drv(0, 0, 0, 0, 1); y_max = 10'd480; paddle_x = 10'd0; paddle_w = 10'd1023;
        expect_all("respawn", 316, 400, 1, 0, 0, 0, 2);
        drv(0, 0, 0, 0, 1); step = 4'd3; expect_all("relaunch", 316, 400, 1, 0, 1, 0, 3);
        drv(0, 1, 0, 0, 0); expect_all("relaunch_tick", 319, 397, 1, 0, 1, 0, 3);
        drv(0, 1, 0, 0, 1); step = 4'd5; expect_all("launch_in_move", 322, 394, 1, 0, 1, 0, 3);
        drv(1, 1, 1, 0, 1); expect_all("reset_mid_move", 316, 400, 1, 0, 0, 0, 0);

        // Paddle line at yl=400; every brick flip sends the ball back onto the full-width paddle.
        drv(0, 0, 0, 0, 0); y_max = 10'd408; step = 4'd4;
        drv(0, 0, 0, 0, 1); expect_speed("speed_launch", 1, 4);
        for (int b = 1; b <= 8; b++) begin
            drv(0, 1, 0, 1, 0);
            drv(0, 1, 0, 0, 0);
`ifdef SPEEDUP_EN
            expect_speed("speedup", 1, (b >= 4) ? 5 : 4);
`else
            expect_speed("speed_fixed", 1, 4);
`endif
        end

        drv(0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
